// File: rtl/uart_carregador_instrucoes_if.sv
// Write port from the UART program loader into instruction memory.
// mem_we is a one-cycle valid with no ready: the memory accepts every strobe, and
// mem_end/mem_dado are meaningful only while mem_we=1 (they hold otherwise).
interface uart_carregador_instrucoes_if;
    logic        mem_we;
    logic [31:0] mem_end;
    logic [31:0] mem_dado;

    modport master (output mem_we, mem_end, mem_dado);
    modport slave  (input  mem_we, mem_end, mem_dado);
endinterface

// File: rtl/uart_carregador_instrucoes.sv
// 8N1 UART receiver feeding a loader that writes a word-count-prefixed, big-endian
// program image into instruction memory, holding the CPU stalled until it is done.
module uart_carregador_instrucoes #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [31:0] END_BASE     = 32'd0
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                rx,
    uart_carregador_instrucoes_if.master        mem,
    output logic                                cpu_parada,
    output logic                                concluido,
    output logic                                erro_quadro,
    output logic [15:0]                         palavras_recebidas,
    output logic [1:0]                          estado_rx_dbg,
    output logic [2:0]                          estado_carga_dbg
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] MEIO   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] ULTIMO = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        INICIO = 2'd1,
        DADOS  = 2'd2,
        PARADA = 2'd3
    } estado_rx_t;

    typedef enum logic [2:0] {
        CAB_ALTO  = 3'd0,
        CAB_BAIXO = 3'd1,
        PALAVRA   = 3'd2,
        CONCLUIDO = 3'd3,
        ERRO      = 3'd4
    } estado_carga_t;

    // rx is asynchronous to clock; idle level is high so the synchronizer resets to 1
    logic rx_meta;
    logic rx_sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    estado_rx_t      estado_rx;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      byte_rx;
    logic            byte_ok;
    logic            erro_byte;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_rx <= OCIOSO;
            cnt       <= '0;
            bit_idx   <= '0;
            byte_rx   <= '0;
            byte_ok   <= 1'b0;
            erro_byte <= 1'b0;
        end else begin
            byte_ok   <= 1'b0;
            erro_byte <= 1'b0;
            case (estado_rx)
                OCIOSO: begin
                    cnt <= '0;
                    if (!rx_sync) begin
                        estado_rx <= INICIO;
                    end
                end
                INICIO: begin
                    // Start bit must still be low at mid-bit, otherwise it was a glitch
                    if (cnt == MEIO) begin
                        cnt       <= '0;
                        bit_idx   <= '0;
                        estado_rx <= rx_sync ? OCIOSO : DADOS;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DADOS: begin
                    if (cnt == ULTIMO) begin
                        cnt     <= '0;
                        byte_rx <= {rx_sync, byte_rx[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            estado_rx <= PARADA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARADA: begin
                    if (cnt == ULTIMO) begin
                        cnt       <= '0;
                        byte_ok   <= rx_sync;
                        erro_byte <= !rx_sync;
                        estado_rx <= OCIOSO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: estado_rx <= OCIOSO;
            endcase
        end
    end

    estado_carga_t estado_carga;
    logic [15:0]   n_total;
    logic [1:0]    k;
    logic [23:0]   parcial;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_carga       <= CAB_ALTO;
            n_total            <= '0;
            k                  <= '0;
            parcial            <= '0;
            mem.mem_we         <= 1'b0;
            mem.mem_end        <= END_BASE;
            mem.mem_dado       <= '0;
            cpu_parada         <= 1'b1;
            concluido          <= 1'b0;
            erro_quadro        <= 1'b0;
            palavras_recebidas <= '0;
        end else begin
            mem.mem_we <= 1'b0;
            case (estado_carga)
                CAB_ALTO: begin
                    if (erro_byte) begin
                        estado_carga <= ERRO;
                        erro_quadro  <= 1'b1;
                    end else if (byte_ok) begin
                        n_total[15:8] <= byte_rx;
                        estado_carga  <= CAB_BAIXO;
                    end
                end
                CAB_BAIXO: begin
                    if (erro_byte) begin
                        estado_carga <= ERRO;
                        erro_quadro  <= 1'b1;
                    end else if (byte_ok) begin
                        n_total[7:0] <= byte_rx;
                        k            <= '0;
                        if ({n_total[15:8], byte_rx} == 16'd0) begin
                            estado_carga <= CONCLUIDO;
                            concluido    <= 1'b1;
                            cpu_parada   <= 1'b0;
                        end else begin
                            estado_carga <= PALAVRA;
                        end
                    end
                end
                PALAVRA: begin
                    if (mem.mem_we) begin
                        // Bookkeeping for the word just strobed; bytes cannot arrive this soon
                        mem.mem_end        <= mem.mem_end + 32'd4;
                        palavras_recebidas <= palavras_recebidas + 16'd1;
                        if (palavras_recebidas + 16'd1 == n_total) begin
                            estado_carga <= CONCLUIDO;
                            concluido    <= 1'b1;
                            cpu_parada   <= 1'b0;
                        end
                    end else if (erro_byte) begin
                        estado_carga <= ERRO;
                        erro_quadro  <= 1'b1;
                        parcial      <= '0;
                        k            <= '0;
                    end else if (byte_ok) begin
                        k <= k + 1'b1;
                        if (k == 2'd3) begin
                            mem.mem_we   <= 1'b1;
                            mem.mem_dado <= {parcial, byte_rx};
                        end else begin
                            parcial <= {parcial[15:0], byte_rx};
                        end
                    end
                end
                CONCLUIDO: begin
                    concluido  <= 1'b1;
                    cpu_parada <= 1'b0;
                end
                ERRO: begin
                    cpu_parada <= 1'b1;
                end
                default: estado_carga <= CAB_ALTO;
            endcase
        end
    end

    assign estado_rx_dbg    = estado_rx;
    assign estado_carga_dbg = estado_carga;

endmodule
